// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Optional round-robin arbitration is enabled with ARB_ROUND_ROBIN_EN.
package ram_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        ARB_RD   = 3'd1,
        ARB_WS   = 3'd2,
        ARB_WP   = 3'd3,
        ARB_WH   = 3'd4,
        ARB_DONE = 3'd5
    } arb_state_e;

    localparam logic ARB_PORT_IF  = 1'b0;
    localparam logic ARB_PORT_MEM = 1'b1;

    localparam int RAM_ADDR_BUS = 20;
    localparam int RAM_BUS      = 32;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU-side request/acknowledge bundle for one SRAM bank.
// master = CPU fetch and memory stages, slave = arbiter.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output if_ack, if_rdata, mem_ack, mem_rdata
    );
endinterface

// File: rtl/ram_port_arbiter_arb_pick.sv
// Combinational grant selection between fetch and data ports.
// Fixed mem priority, or alternating grant under ARB_ROUND_ROBIN_EN.
module arb_pick
    import ram_port_arbiter_pkg::*;
(
    input  logic if_req_i,
    input  logic mem_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_i,
`endif
    output logic valid_o,
    output logic port_o
);

    always_comb begin
        valid_o = if_req_i | mem_req_i;
        port_o  = ARB_PORT_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req_i && mem_req_i)
            port_o = (last_i == ARB_PORT_MEM) ? ARB_PORT_IF : ARB_PORT_MEM;
        else if (mem_req_i)
            port_o = ARB_PORT_MEM;
`else
        if (mem_req_i)
            port_o = ARB_PORT_MEM;
`endif
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Async SRAM bank arbiter: fetch vs data port, strobe sequencing.
// Build with ARB_ROUND_ROBIN_EN for alternating grants under contention.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = RAM_ADDR_BUS,
    parameter int DATA_W  = RAM_BUS,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we
);

    localparam logic [2:0] WAIT_N = 3'(RD_WAIT);

    arb_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_q, oe_q, we_q, drv_q;
    logic              if_ack_q, mem_ack_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              grant_v, grant_p;
    logic              last_cnt;

    assign last_cnt = (cnt_q == WAIT_N);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_q <= ARB_PORT_IF;
        else if (state_q == ARB_IDLE && grant_v)
            last_q <= grant_p;
    end

    arb_pick u_pick (
        .if_req_i  (bus.if_req),
        .mem_req_i (bus.mem_req),
        .last_i    (last_q),
        .valid_o   (grant_v),
        .port_o    (grant_p)
    );
`else
    arb_pick u_pick (
        .if_req_i  (bus.if_req),
        .mem_req_i (bus.mem_req),
        .valid_o   (grant_v),
        .port_o    (grant_p)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_v) begin
                    port_d = grant_p;
                    cnt_d  = '0;
                    if (grant_p == ARB_PORT_MEM) begin
                        addr_d  = bus.mem_addr;
                        wdata_d = bus.mem_wdata;
                        state_d = bus.mem_we ? ARB_WS : ARB_RD;
                    end else begin
                        addr_d  = bus.if_addr;
                        state_d = ARB_RD;
                    end
                end
            end
            ARB_RD: begin
                if (last_cnt) state_d = ARB_DONE;
                else          cnt_d   = cnt_q + 3'd1;
            end
            ARB_WS: begin
                state_d = ARB_WP;
                cnt_d   = '0;
            end
            ARB_WP: begin
                if (last_cnt) state_d = ARB_WH;
                else          cnt_d   = cnt_q + 3'd1;
            end
            ARB_WH:   state_d = ARB_DONE;
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Strobes and acks are registered from the next state so pins
    // change only on the clock edge that enters each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            port_q      <= ARB_PORT_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            drv_q       <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ce_q      <= !(state_d inside {ARB_RD, ARB_WS, ARB_WP, ARB_WH});
            oe_q      <= (state_d != ARB_RD);
            we_q      <= (state_d != ARB_WP);
            drv_q     <= (state_d inside {ARB_WS, ARB_WP, ARB_WH});
            if_ack_q  <= (state_d == ARB_DONE) && (port_d == ARB_PORT_IF);
            mem_ack_q <= (state_d == ARB_DONE) && (port_d == ARB_PORT_MEM);
            if (state_q == ARB_RD && last_cnt) begin
                if (port_q == ARB_PORT_MEM) mem_rdata_q <= ram_data;
                else                        if_rdata_q  <= ram_data;
            end
        end
    end

    assign ram_addr      = addr_q;
    assign ram_ce        = ce_q;
    assign ram_oe        = oe_q;
    assign ram_we        = we_q;
    assign ram_data      = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign bus.if_ack    = if_ack_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: two instances (RD_WAIT=1 and 3)
// each with a behavioural async SRAM on its pins.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    ram_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) b1 ();
    ram_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) b3 ();

    wire  [31:0] rd1, rd3;
    logic [19:0] ra1, ra3;
    logic        ce1, oe1, we1, ce3, oe3, we3;

    ram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .RD_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1),
        .ram_addr(ra1), .ram_data(rd1),
        .ram_ce(ce1), .ram_oe(oe1), .ram_we(we1)
    );

    ram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .RD_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3),
        .ram_addr(ra3), .ram_data(rd3),
        .ram_ce(ce3), .ram_oe(oe3), .ram_we(we3)
    );

    // Behavioural SRAMs, 64 words each
    logic [31:0] sram1 [64];
    logic [31:0] sram3 [64];
    logic        pre_we1 = 1'b0, pre_we3 = 1'b0;
    logic [5:0]  pre_a = '0;
    logic [31:0] pre_d = '0;

    assign rd1 = (!ce1 && !oe1) ? sram1[ra1[5:0]] : 32'bz;
    assign rd3 = (!ce3 && !oe3) ? sram3[ra3[5:0]] : 32'bz;

    always @(posedge clk) begin
        if (pre_we1)              sram1[pre_a] <= pre_d;
        else if (!ce1 && !we1)    sram1[ra1[5:0]] <= rd1;
        if (pre_we3)              sram3[pre_a] <= pre_d;
        else if (!ce3 && !we3)    sram3[ra3[5:0]] <= rd3;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe run lengths, write-phase bus contents, ack widths
    int          oe_run1 = 0, we_run1 = 0, oe_len1 = 0, we_len1 = 0;
    int          oe_run3 = 0, we_run3 = 0, oe_len3 = 0, we_len3 = 0;
    logic [19:0] exp_wa1 = '0;
    logic [31:0] exp_wd1 = '0;
    logic        pm1 = 0, pi1 = 0, pm3 = 0, pi3 = 0;

    always @(negedge clk) begin
        if (!oe1) oe_run1++;
        else if (oe_run1 != 0) begin oe_len1 = oe_run1; oe_run1 = 0; end
        if (!we1) we_run1++;
        else if (we_run1 != 0) begin we_len1 = we_run1; we_run1 = 0; end
        if (!oe3) oe_run3++;
        else if (oe_run3 != 0) begin oe_len3 = oe_run3; oe_run3 = 0; end
        if (!we3) we_run3++;
        else if (we_run3 != 0) begin we_len3 = we_run3; we_run3 = 0; end
        if (rst && !ce1 && oe1) begin
            check("w1_addr", 64'(ra1), 64'(exp_wa1));
            check("w1_data", 64'(rd1), 64'(exp_wd1));
        end
        if (!oe1 || !we1) check("strobe1", {62'd0, ce1, !oe1 && !we1}, 64'd0);
        if (!oe3 || !we3) check("strobe3", {62'd0, ce3, !oe3 && !we3}, 64'd0);
        if (b1.mem_ack || b1.if_ack)
            check("ack1_w", {61'd0, b1.mem_ack && pm1, b1.if_ack && pi1,
                             b1.if_ack && b1.mem_ack}, 64'd0);
        if (b3.mem_ack || b3.if_ack)
            check("ack3_w", {61'd0, b3.mem_ack && pm3, b3.if_ack && pi3,
                             b3.if_ack && b3.mem_ack}, 64'd0);
        pm1 = b1.mem_ack; pi1 = b1.if_ack;
        pm3 = b3.mem_ack; pi3 = b3.if_ack;
    end

    task automatic preload(input logic sel3, input logic [5:0] a,
                           input logic [31:0] d);
        pre_a = a;
        pre_d = d;
        if (sel3) pre_we3 = 1'b1;
        else      pre_we1 = 1'b1;
        @(posedge clk);
        #1;
        pre_we1 = 1'b0;
        pre_we3 = 1'b0;
    endtask

    task automatic f1(input logic [19:0] a, output int lat);
        lat = -1;
        b1.if_addr = a;
        b1.if_req  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (b1.if_ack) begin lat = n; break; end
        end
        b1.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic m1(input logic we, input logic [19:0] a,
                      input logic [31:0] d, output int lat);
        lat = -1;
        exp_wa1 = a;
        exp_wd1 = d;
        b1.mem_we    = we;
        b1.mem_addr  = a;
        b1.mem_wdata = d;
        b1.mem_req   = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (b1.mem_ack) begin lat = n; break; end
        end
        b1.mem_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic m3(input logic we, input logic [19:0] a,
                      input logic [31:0] d, output int lat);
        lat = -1;
        b3.mem_we    = we;
        b3.mem_addr  = a;
        b3.mem_wdata = d;
        b3.mem_req   = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (b3.mem_ack) begin lat = n; break; end
        end
        b3.mem_req = 1'b0;
        @(negedge clk);
    endtask

    int         lat;
    int         mc, ic;
    logic [7:0] seq, exp_seq;
    logic       found;

    initial begin
        b1.if_req = 0; b1.if_addr = '0; b1.mem_req = 0; b1.mem_we = 0;
        b1.mem_addr = '0; b1.mem_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.mem_req = 0; b3.mem_we = 0;
        b3.mem_addr = '0; b3.mem_wdata = '0;

        preload(1'b0, 6'h10, 32'h3C08BFC0);
        preload(1'b0, 6'h04, 32'h11112222);
        preload(1'b0, 6'h05, 32'h33334444);
        preload(1'b1, 6'h08, 32'hCAFEF00D);
        @(negedge clk);

        check("rst_strobes", {61'd0, ce1, oe1, we1}, 64'd7);
        check("rst_addr", 64'(ra1), 64'd0);
        check("rst_acks", {62'd0, b1.if_ack, b1.mem_ack}, 64'd0);
        check("rst_rdata", {b1.if_rdata, b1.mem_rdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        f1(20'h00010, lat);
        check("fetch_lat", 64'(lat), 64'd3);
        check("fetch_data", 64'(b1.if_rdata), 64'h3C08BFC0);
        check("fetch_oe_len", 64'(oe_len1), 64'd2);

        m1(1'b1, 20'h00020, 32'hDEADBEEF, lat);
        check("wr_lat", 64'(lat), 64'd5);
        check("wr_we_len", 64'(we_len1), 64'd2);
        m1(1'b0, 20'h00020, 32'h0, lat);
        check("rd_lat", 64'(lat), 64'd3);
        check("rd_data", 64'(b1.mem_rdata), 64'hDEADBEEF);

        // Fresh reset so round-robin starts from last-grant = if
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mc = 0; ic = 0; seq = '0;
        b1.if_addr = 20'h00004;
        b1.mem_addr = 20'h00005;
        b1.mem_we = 1'b0;
        b1.if_req = 1'b1;
        b1.mem_req = 1'b1;
        for (int n = 0; n < 300 && (mc < 4 || ic < 4); n++) begin
            @(negedge clk);
            if (b1.mem_ack) begin
                seq = {seq[6:0], 1'b1};
                mc++;
                if (mc == 4) b1.mem_req = 1'b0;
            end
            if (b1.if_ack) begin
                seq = {seq[6:0], 1'b0};
                ic++;
                if (ic == 4) b1.if_req = 1'b0;
            end
        end
        b1.if_req = 1'b0;
        b1.mem_req = 1'b0;
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 8'b1010_1010;
`else
        exp_seq = 8'b1111_0000;
`endif
        check("cont_counts", {32'(mc), 32'(ic)}, {32'd4, 32'd4});
        check("cont_order", 64'(seq), 64'(exp_seq));
        check("cont_if_data", 64'(b1.if_rdata), 64'h11112222);
        check("cont_mem_data", 64'(b1.mem_rdata), 64'h33334444);

        m3(1'b0, 20'h00008, 32'h0, lat);
        check("w3_rd_lat", 64'(lat), 64'd5);
        check("w3_rd_data", 64'(b3.mem_rdata), 64'hCAFEF00D);
        check("w3_oe_len", 64'(oe_len3), 64'd4);
        m3(1'b1, 20'h00009, 32'h5A5AA5A5, lat);
        check("w3_wr_lat", 64'(lat), 64'd7);
        check("w3_we_len", 64'(we_len3), 64'd4);
        m3(1'b0, 20'h00009, 32'h0, lat);
        check("w3_rb_data", 64'(b3.mem_rdata), 64'h5A5AA5A5);

        // Reset while the write pulse is active
        exp_wa1 = 20'h00006;
        exp_wd1 = 32'h01234567;
        b1.mem_we = 1'b1;
        b1.mem_addr = 20'h00006;
        b1.mem_wdata = 32'h01234567;
        b1.mem_req = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!we1) begin found = 1'b1; break; end
        end
        check("mid_wp_seen", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_strobes", {61'd0, ce1, oe1, we1}, 64'd7);
        check("mid_ack", {62'd0, b1.if_ack, b1.mem_ack}, 64'd0);
        check("mid_rdata", 64'(b1.if_rdata), 64'd0);
        @(negedge clk);
        check("mid_ack2", {62'd0, b1.if_ack, b1.mem_ack}, 64'd0);
        b1.mem_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        f1(20'h00004, lat);
        check("post_lat", 64'(lat), 64'd3);
        check("post_data", 64'(b1.if_rdata), 64'h11112222);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
